commit_unit_multi: RTL and testbench

//  In-order retire stage between ROB head and register file, W lanes wide.

---
 rtl/commit_unit_multi.sv | 152 +++++++++++++++
 tb/tb_commit_unit_multi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit_multi.sv
`default_nettype none
// ============================================================================
// Module  : commit_unit_multi
// Brief   : In-order multi-lane retire stage between ROB head and regfile.
//           Handles store commit handshakes, mispredict flushes and counts
//           retired instructions.
// Revision: 1.0  initial release
// ============================================================================
module commit_unit_multi #(
  parameter  int DATA_W    = 16,
  parameter  int TAG_W     = 3,
  parameter  int W         = 2,
  parameter  int FLUSH_CYC = 2,
  parameter  int CNT_W     = 32,
  localparam int K_W       = $clog2(W + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 rob_valid,
  input  logic [W-1:0][3:0]            rob_opcode,
  input  logic [W-1:0][2:0]            rob_dest,
  input  logic [W-1:0]                 rob_has_dest,
  input  logic [W-1:0][DATA_W-1:0]     rob_value,
  input  logic [W-1:0][TAG_W-1:0]      rob_tag,
  input  logic [W-1:0]                 rob_mispredict,
  input  logic [W-1:0][15:0]           rob_target,
  output logic [K_W-1:0]               rob_retire,
  output logic [W-1:0]                 rf_we,
  output logic [W-1:0][2:0]            rf_dest,
  output logic [W-1:0][DATA_W-1:0]     rf_value,
  output logic [W-1:0][TAG_W-1:0]      rf_tag,
  output logic                         st_req,
  input  logic                         st_ack,
  output logic                         flush_out,
  output logic [15:0]                  flush_pc,
  output logic [CNT_W-1:0]             retired_cnt
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_ST  = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  logic [1:0]      r_state;
  logic [FC_W-1:0] r_flush_cnt;

  logic [K_W-1:0]  w_k;
  logic [W-1:0]    w_mask;
  logic            w_stop;
  logic            w_st_head;
  logic            w_mp;
  logic [15:0]     w_mp_pc;

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STB) || (op == OP_STI);
  endfunction

  // Longest committable prefix: stops at a hole, at any store (a head store
  // goes through the memory handshake instead), or just after a mispredict.
  always_comb begin
    w_k       = '0;
    w_mask    = '0;
    w_stop    = 1'b0;
    w_st_head = 1'b0;
    w_mp      = 1'b0;
    w_mp_pc   = '0;
    for (int i = 0; i < W; i++) begin
      if (!w_stop) begin
        if (!rob_valid[i]) begin
          w_stop = 1'b1;
        end else if (is_store(rob_opcode[i])) begin
          w_stop    = 1'b1;
          w_st_head = (i == 0);
        end else begin
          w_mask[i] = 1'b1;
          w_k       = w_k + K_W'(1);
          if (rob_mispredict[i]) begin
            w_mp    = 1'b1;
            w_mp_pc = rob_target[i];
            w_stop  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rob_retire = '0;
    case (r_state)
      RUN:     rob_retire = w_k;
      ST_WAIT: if (st_ack) rob_retire = K_W'(1);
      default: rob_retire = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      rf_we       <= '0;
      rf_dest     <= '0;
      rf_value    <= '0;
      rf_tag      <= '0;
      st_req      <= 1'b0;
      flush_out   <= 1'b0;
      flush_pc    <= '0;
      retired_cnt <= '0;
    end else begin
      retired_cnt <= retired_cnt + CNT_W'(rob_retire);
      rf_we       <= '0;
      case (r_state)
        RUN: begin
          rf_we    <= w_mask & rob_has_dest;
          rf_dest  <= rob_dest;
          rf_value <= rob_value;
          rf_tag   <= rob_tag;
          if (w_mp) begin
            flush_out   <= 1'b1;
            flush_pc    <= w_mp_pc;
            r_flush_cnt <= FC_W'(FLUSH_CYC - 1);
            r_state     <= FLUSH;
          end else if (w_st_head) begin
            st_req  <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (st_ack) begin
            st_req  <= 1'b0;
            r_state <= RUN;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) begin
            flush_out <= 1'b0;
            r_state   <= RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_commit_unit_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_commit_unit_multi
// Brief   : Scoreboard bench for commit_unit_multi (W=2); a second instance
//           with a 2-bit counter exercises counter wrap on the same stimulus.
// Revision: 1.0  initial release
// ============================================================================
module tb_commit_unit_multi;

  localparam int FLUSH_CYC = 2;

  logic             clk;
  logic             rst;
  logic [1:0]       rob_valid;
  logic [1:0][3:0]  rob_opcode;
  logic [1:0][2:0]  rob_dest;
  logic [1:0]       rob_has_dest;
  logic [1:0][15:0] rob_value;
  logic [1:0][2:0]  rob_tag;
  logic [1:0]       rob_mispredict;
  logic [1:0][15:0] rob_target;
  logic             st_ack;

  logic [1:0]       rob_retire;
  logic [1:0]       rf_we;
  logic [1:0][2:0]  rf_dest;
  logic [1:0][15:0] rf_value;
  logic [1:0][2:0]  rf_tag;
  logic             st_req;
  logic             flush_out;
  logic [15:0]      flush_pc;
  logic [31:0]      retired_cnt;

  logic [1:0]       rob_retire_2;
  logic [1:0]       rf_we_2;
  logic [1:0][2:0]  rf_dest_2;
  logic [1:0][15:0] rf_value_2;
  logic [1:0][2:0]  rf_tag_2;
  logic             st_req_2;
  logic             flush_out_2;
  logic [15:0]      flush_pc_2;
  logic [1:0]       retired_cnt_2;

  commit_unit_multi #(.DATA_W(16), .TAG_W(3), .W(2), .FLUSH_CYC(FLUSH_CYC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rob_valid(rob_valid), .rob_opcode(rob_opcode), .rob_dest(rob_dest),
    .rob_has_dest(rob_has_dest), .rob_value(rob_value), .rob_tag(rob_tag),
    .rob_mispredict(rob_mispredict), .rob_target(rob_target), .rob_retire(rob_retire),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_value(rf_value), .rf_tag(rf_tag), .st_req(st_req),
    .st_ack(st_ack), .flush_out(flush_out), .flush_pc(flush_pc), .retired_cnt(retired_cnt)
  );

  commit_unit_multi #(.DATA_W(16), .TAG_W(3), .W(2), .FLUSH_CYC(FLUSH_CYC), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .rob_valid(rob_valid), .rob_opcode(rob_opcode), .rob_dest(rob_dest),
    .rob_has_dest(rob_has_dest), .rob_value(rob_value), .rob_tag(rob_tag),
    .rob_mispredict(rob_mispredict), .rob_target(rob_target), .rob_retire(rob_retire_2),
    .rf_we(rf_we_2), .rf_dest(rf_dest_2), .rf_value(rf_value_2), .rf_tag(rf_tag_2),
    .st_req(st_req_2), .st_ack(st_ack), .flush_out(flush_out_2), .flush_pc(flush_pc_2),
    .retired_cnt(retired_cnt_2)
  );

  typedef struct {
    int               k;
    logic [1:0]       we;
    logic [1:0][2:0]  dest;
    logic [1:0][15:0] val;
    logic [1:0][2:0]  tag;
    logic [31:0]      cnt;
    logic             fl;
    logic [15:0]      pc;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] req;
  } chk_t;

  exp_t        exp_q[$];
  chk_t        chk_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 0;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_ST  = 4'b0111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: retire events pop the scoreboard; registered effects are checked
  // the following cycle.
  initial begin
    exp_t pend;
    bit   have_pend;
    int   fl_len;
    chk_t c;
    have_pend = 0;
    fl_len    = 0;
    forever begin
      @(negedge clk);
      if (have_pend) begin
        have_pend = 0;
        cmp("rf_we", 32'(rf_we), 32'(pend.we));
        for (int i = 0; i < 2; i++) begin
          if (pend.we[i]) begin
            cmp($sformatf("rf_dest[%0d]", i), 32'(rf_dest[i]), 32'(pend.dest[i]));
            cmp($sformatf("rf_value[%0d]", i), 32'(rf_value[i]), 32'(pend.val[i]));
            cmp($sformatf("rf_tag[%0d]", i), 32'(rf_tag[i]), 32'(pend.tag[i]));
          end
        end
        cmp("retired_cnt", retired_cnt, pend.cnt);
        cmp("retired_cnt_w2", 32'(retired_cnt_2), pend.cnt & 32'd3);
        cmp("flush_out", 32'(flush_out), 32'(pend.fl));
        if (pend.fl) cmp("flush_pc", 32'(flush_pc), 32'(pend.pc));
        cmp("st_req_after_retire", 32'(st_req), 32'd0);
      end
      if (rob_retire != 0) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_retire", 32'(rob_retire), 32'd0);
        end else begin
          pend = exp_q.pop_front();
          cmp("rob_retire", 32'(rob_retire), 32'(pend.k));
          have_pend = 1;
        end
      end
      if (flush_out) begin
        fl_len++;
      end else if (fl_len != 0) begin
        cmp("flush_len", 32'(fl_len), 32'(FLUSH_CYC));
        fl_len = 0;
      end
      while (chk_q.size() != 0) begin
        c = chk_q.pop_front();
        cmp(c.nm, c.act, c.req);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    chk_t c;
    c.nm = nm; c.act = act; c.req = req;
    chk_q.push_back(c);
  endtask

  task automatic clear_in();
    rob_valid = '0; rob_opcode = '0; rob_dest = '0; rob_has_dest = '0;
    rob_value = '0; rob_tag = '0; rob_mispredict = '0; rob_target = '0; st_ack = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [3:0] op, input logic [2:0] d, input logic hd,
                          input logic [15:0] v, input logic [2:0] t, input logic mp,
                          input logic [15:0] tgt);
    rob_valid[i] = 1'b1; rob_opcode[i] = op; rob_dest[i] = d; rob_has_dest[i] = hd;
    rob_value[i] = v; rob_tag[i] = t; rob_mispredict[i] = mp; rob_target[i] = tgt;
  endtask

  task automatic push_exp(input int k, input logic [1:0] we, input logic [2:0] d0, input logic [2:0] d1,
                          input logic [15:0] v0, input logic [15:0] v1, input logic [2:0] t0,
                          input logic [2:0] t1, input logic fl, input logic [15:0] pc);
    exp_t e;
    exp_cnt  = exp_cnt + 32'(k);
    e.k = k; e.we = we; e.dest[0] = d0; e.dest[1] = d1; e.val[0] = v0; e.val[1] = v1;
    e.tag[0] = t0; e.tag[1] = t1; e.cnt = exp_cnt; e.fl = fl; e.pc = pc;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    push_chk("reset_rob_retire", 32'(rob_retire), 32'd0);
    push_chk("reset_rf_we", 32'(rf_we), 32'd0);
    push_chk("reset_rf_value", 32'(rf_value), 32'd0);
    push_chk("reset_st_req", 32'(st_req), 32'd0);
    push_chk("reset_flush_out", 32'(flush_out), 32'd0);
    push_chk("reset_flush_pc", 32'(flush_pc), 32'd0);
    push_chk("reset_retired_cnt", retired_cnt, 32'd0);
    rst = 1'b0;

    // Two independent ADDs retire together.
    tick();
    set_lane(0, OP_ADD, 3'd1, 1'b1, 16'd5, 3'd0, 1'b0, 16'h0);
    set_lane(1, OP_ADD, 3'd2, 1'b1, 16'd7, 3'd1, 1'b0, 16'h0);
    push_exp(2, 2'b11, 3'd1, 3'd2, 16'd5, 16'd7, 3'd0, 3'd1, 1'b0, 16'h0);
    tick();
    clear_in();

    // ADD then store: only the ADD retires; the store then waits for ack.
    tick();
    set_lane(0, OP_ADD, 3'd4, 1'b1, 16'd9, 3'd2, 1'b0, 16'h0);
    set_lane(1, OP_ST, 3'd0, 1'b0, 16'h0055, 3'd3, 1'b0, 16'h0);
    push_exp(1, 2'b01, 3'd4, 3'd0, 16'd9, 16'h0, 3'd2, 3'd0, 1'b0, 16'h0);
    tick();
    clear_in();
    set_lane(0, OP_ST, 3'd0, 1'b0, 16'h0055, 3'd3, 1'b0, 16'h0);
    @(negedge clk);
    push_chk("store_head_retire", 32'(rob_retire), 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      @(negedge clk);
      push_chk("st_wait_st_req", 32'(st_req), 32'd1);
      push_chk("st_wait_retire", 32'(rob_retire), 32'd0);
    end
    tick();
    st_ack = 1'b1;
    push_exp(1, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 16'h0);
    tick();
    clear_in();

    // Head mispredict: flush, younger lane ignored.
    tick();
    set_lane(0, OP_BR, 3'd0, 1'b0, 16'h0, 3'd4, 1'b1, 16'h3000);
    set_lane(1, OP_ADD, 3'd5, 1'b1, 16'h0066, 3'd5, 1'b0, 16'h0);
    push_exp(1, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b1, 16'h3000);
    tick();
    clear_in();
    set_lane(0, OP_ADD, 3'd5, 1'b1, 16'h0066, 3'd5, 1'b0, 16'h0);
    @(negedge clk);
    push_chk("flush_retire_c1", 32'(rob_retire), 32'd0);
    tick();
    @(negedge clk);
    push_chk("flush_retire_c2", 32'(rob_retire), 32'd0);
    tick();
    clear_in();

    // Mispredict in lane 1: both retire, its dest write happens.
    tick();
    set_lane(0, OP_ADD, 3'd6, 1'b1, 16'h0077, 3'd6, 1'b0, 16'h0);
    set_lane(1, OP_JSR, 3'd7, 1'b1, 16'h1234, 3'd7, 1'b1, 16'h4000);
    push_exp(2, 2'b11, 3'd6, 3'd7, 16'h0077, 16'h1234, 3'd6, 3'd7, 1'b1, 16'h4000);
    tick();
    clear_in();
    tick();
    tick();

    // Same destination in both lanes; also wraps the 2-bit counter 3 -> 1.
    set_lane(0, OP_ADD, 3'd3, 1'b1, 16'h0011, 3'd4, 1'b0, 16'h0);
    set_lane(1, OP_ADD, 3'd3, 1'b1, 16'h0022, 3'd5, 1'b0, 16'h0);
    push_exp(2, 2'b11, 3'd3, 3'd3, 16'h0011, 16'h0022, 3'd4, 3'd5, 1'b0, 16'h0);
    tick();
    clear_in();

    // Gap at the head: nothing retires.
    tick();
    set_lane(1, OP_ADD, 3'd2, 1'b1, 16'h0099, 3'd1, 1'b0, 16'h0);
    @(negedge clk);
    push_chk("gap_retire", 32'(rob_retire), 32'd0);
    tick();
    clear_in();
    @(negedge clk);
    push_chk("gap_rf_we", 32'(rf_we), 32'd0);

    // Reset while waiting on a store.
    tick();
    set_lane(0, OP_ST, 3'd0, 1'b0, 16'h00aa, 3'd2, 1'b0, 16'h0);
    tick();
    #2;
    push_chk("pre_rst_st_req", 32'(st_req), 32'd1);
    rst = 1'b1;
    #1;
    push_chk("rst_st_req", 32'(st_req), 32'd0);
    push_chk("rst_retired_cnt", retired_cnt, 32'd0);
    push_chk("rst_retired_cnt_w2", 32'(retired_cnt_2), 32'd0);
    clear_in();
    exp_cnt = 0;
    tick();
    rst = 1'b0;

    // Counting restarts from zero after reset.
    tick();
    set_lane(0, OP_ADD, 3'd1, 1'b1, 16'h0101, 3'd0, 1'b0, 16'h0);
    push_exp(1, 2'b01, 3'd1, 3'd0, 16'h0101, 16'h0, 3'd0, 3'd0, 1'b0, 16'h0);
    tick();
    clear_in();
    repeat (3) tick();
    push_chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
